// File: rtl/hermes_pkt_tx_if.sv
// Producer write port and Hermes credit link of the packet transmitter, plus its status lines.
// master is the producer/receiver environment, slave is the transmitter.
interface hermes_pkt_tx_if #(
   parameter int HERMES_FLIT_SIZE = 32,
   parameter int BUFFER_SIZE      = 16
);
   logic                          wr_en;
   logic                          wr_eop;
   logic [HERMES_FLIT_SIZE-1:0]   wr_data;
   logic                          wr_full;
   logic                          noc_tx;
   logic                          noc_eop;
   logic                          noc_credit;
   logic [HERMES_FLIT_SIZE-1:0]   noc_data;
   logic [$clog2(BUFFER_SIZE):0]  pkts;
   logic                          busy;
   logic                          err;

   modport master (
      output wr_en, wr_eop, wr_data, noc_credit,
      input  wr_full, noc_tx, noc_eop, noc_data, pkts, busy, err
   );

   modport slave (
      input  wr_en, wr_eop, wr_data, noc_credit,
      output wr_full, noc_tx, noc_eop, noc_data, pkts, busy, err
   );
endinterface

// File: rtl/hermes_pkt_tx.sv
// Hermes credit-based flit transmitter: FIFO-buffers producer flits and streams them to a
// receiver, optionally holding each packet until its EOP flit has been buffered.
module hermes_pkt_tx #(
   parameter int HERMES_FLIT_SIZE = 32,
   parameter int BUFFER_SIZE      = 16,
   parameter bit STORE_FORWARD    = 1'b1
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   hermes_pkt_tx_if.slave bus
);
   localparam int PW = $clog2(BUFFER_SIZE);
   localparam int CW = PW + 1;

   typedef enum logic {IDLE, PKT} state_t;

   typedef struct packed {
      logic                        eop;
      logic [HERMES_FLIT_SIZE-1:0] data;
   } flit_t;

   flit_t         mem [BUFFER_SIZE];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] pkts;
   state_t        state;
   logic          force_cut;
   logic          err;

   logic          empty;
   logic          full;
   logic          tx;
   logic          head_eop;
   logic          wr_accept;
   logic          rd_xfer;
   logic          oversize;

   // Everything the receiver sees is decoded from registered state only, never from credit.
   // The oversize case is a store-forward packet that can never complete inside the FIFO.
   always_comb begin
      empty     = (count == '0);
      full      = (count == CW'(BUFFER_SIZE));
      head_eop  = mem[rd_ptr].eop;
      if (state == PKT) begin
         tx = !empty;
      end else begin
         tx = !empty && (!STORE_FORWARD || (pkts != '0) || force_cut);
      end
      wr_accept = bus.wr_en && !full;
      rd_xfer   = tx && bus.noc_credit;
      oversize  = STORE_FORWARD && (state == IDLE) && full && (pkts == '0);
   end

   // Flit storage is not reset; contents are meaningless until written.
   always_ff @(posedge clk_i) begin
      if (wr_accept) begin
         mem[wr_ptr] <= {bus.wr_eop, bus.wr_data};
      end
   end

   // Pointers, occupancy, packet count, packet FSM and the sticky oversize error.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         pkts      <= '0;
         state     <= IDLE;
         force_cut <= 1'b0;
         err       <= 1'b0;
      end else begin
         if (wr_accept) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (rd_xfer) begin
            rd_ptr <= rd_ptr + PW'(1);
         end

         if (wr_accept && !rd_xfer) begin
            count <= count + CW'(1);
         end else if (!wr_accept && rd_xfer) begin
            count <= count - CW'(1);
         end

         if ((wr_accept && bus.wr_eop) && !(rd_xfer && head_eop)) begin
            pkts <= pkts + CW'(1);
         end else if (!(wr_accept && bus.wr_eop) && (rd_xfer && head_eop)) begin
            pkts <= pkts - CW'(1);
         end

         case (state)
            IDLE: begin
               if (rd_xfer && !head_eop) begin
                  state <= PKT;
               end
            end
            PKT: begin
               if (rd_xfer && head_eop) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (rd_xfer && head_eop) begin
            force_cut <= 1'b0;
         end else if (oversize) begin
            force_cut <= 1'b1;
         end

         if (oversize) begin
            err <= 1'b1;
         end
      end
   end

   assign bus.wr_full  = full;
   assign bus.noc_tx   = tx;
   assign bus.noc_eop  = head_eop;
   assign bus.noc_data = mem[rd_ptr].data;
   assign bus.pkts     = pkts;
   assign bus.busy     = !empty || (state == PKT);
   assign bus.err      = err;
endmodule

// File: tb/tb_hermes_pkt_tx.sv
// Bench for hermes_pkt_tx: a cut-through and a store-forward instance (4-flit FIFOs) checked
// every cycle against a queue-based packet model of the transmitter.
module tb_hermes_pkt_tx;
   localparam int FW  = 32;
   localparam int BS  = 4;
   localparam int PWD = $clog2(BS) + 1;

   typedef struct packed {
      logic          eop;
      logic [FW-1:0] data;
   } flit_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          sel;
   logic          wr_en;
   logic          wr_eop;
   logic [FW-1:0] wr_data;
   logic          credit;

   always #5 clk = ~clk;

   hermes_pkt_tx_if #(.HERMES_FLIT_SIZE(FW), .BUFFER_SIZE(BS)) if_ct ();
   hermes_pkt_tx_if #(.HERMES_FLIT_SIZE(FW), .BUFFER_SIZE(BS)) if_sf ();

   // sel=0 drives the cut-through instance, sel=1 the store-forward one; the other sits idle.
   assign if_ct.wr_en      = !sel && wr_en;
   assign if_ct.wr_eop     = wr_eop;
   assign if_ct.wr_data    = wr_data;
   assign if_ct.noc_credit = !sel && credit;
   assign if_sf.wr_en      = sel && wr_en;
   assign if_sf.wr_eop     = wr_eop;
   assign if_sf.wr_data    = wr_data;
   assign if_sf.noc_credit = sel && credit;

   hermes_pkt_tx #(.HERMES_FLIT_SIZE(FW), .BUFFER_SIZE(BS), .STORE_FORWARD(1'b0)) dut_ct (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (if_ct.slave)
   );

   hermes_pkt_tx #(.HERMES_FLIT_SIZE(FW), .BUFFER_SIZE(BS), .STORE_FORWARD(1'b1)) dut_sf (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (if_sf.slave)
   );

   logic           obs_tx;
   logic           obs_eop;
   logic           obs_full;
   logic           obs_busy;
   logic           obs_err;
   logic [FW-1:0]  obs_data;
   logic [PWD-1:0] obs_pkts;

   always_comb begin
      if (sel) begin
         obs_tx   = if_sf.noc_tx;
         obs_eop  = if_sf.noc_eop;
         obs_full = if_sf.wr_full;
         obs_busy = if_sf.busy;
         obs_err  = if_sf.err;
         obs_data = if_sf.noc_data;
         obs_pkts = if_sf.pkts;
      end else begin
         obs_tx   = if_ct.noc_tx;
         obs_eop  = if_ct.noc_eop;
         obs_full = if_ct.wr_full;
         obs_busy = if_ct.busy;
         obs_err  = if_ct.err;
         obs_data = if_ct.noc_data;
         obs_pkts = if_ct.pkts;
      end
   end

   flit_t mq[$];
   bit    m_mid;
   bit    m_force;
   bit    m_err;
   int    checks    = 0;
   int    errors    = 0;
   int    delivered = 0;
   int    cyc       = 0;
   int    cr_mode   = 1;

   function automatic int eop_count();
      int e = 0;
      foreach (mq[i]) begin
         if (mq[i].eop) e++;
      end
      return e;
   endfunction

   // A flit is offered when buffered and either mid-packet, cut-through, a whole packet is in, or forced.
   function automatic bit exp_tx();
      return (mq.size() > 0) && (m_mid || !sel || (eop_count() > 0) || m_force);
   endfunction

   function automatic logic pick_credit();
      case (cr_mode)
         0:       return 1'b0;
         1:       return 1'b1;
         2:       return (cyc % 3 == 0);
         default: return 1'($urandom_range(1, 0));
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic checkOutput();
      bit etx;
      etx = exp_tx();
      chk("noc_tx", 32'(obs_tx), 32'(etx));
      if (etx) begin
         chk("noc_data", obs_data, mq[0].data);
         chk("noc_eop", 32'(obs_eop), 32'(mq[0].eop));
      end
      chk("wr_full", 32'(obs_full), 32'(mq.size() == BS));
      chk("pkts", 32'(obs_pkts), 32'(eop_count()));
      chk("busy", 32'(obs_busy), 32'((mq.size() > 0) || m_mid));
      chk("err", 32'(obs_err), 32'(m_err));
   endtask

   // One clock cycle: check current outputs, drive inputs, then advance the model at the edge.
   task automatic applyStimulus(input logic en, input logic eop, input logic [FW-1:0] data);
      bit    acc;
      bit    xf;
      bit    cond;
      flit_t f;
      flit_t nf;
      checkOutput();
      wr_en   = en;
      wr_eop  = eop;
      wr_data = data;
      credit  = pick_credit();
      acc  = en && (mq.size() < BS);
      xf   = exp_tx() && credit;
      cond = sel && !m_mid && (mq.size() == BS) && (eop_count() == 0);
      @(posedge clk);
      cyc++;
      if (xf) begin
         f = mq.pop_front();
         delivered++;
         if (f.eop) begin
            m_mid   = 1'b0;
            m_force = 1'b0;
         end else begin
            m_mid = 1'b1;
         end
      end
      if (acc) begin
         nf.eop  = eop;
         nf.data = data;
         mq.push_back(nf);
      end
      if (cond) begin
         m_force = 1'b1;
         m_err   = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic pushFlit(input logic eop, input logic [FW-1:0] data);
      int guard = 0;
      while ((mq.size() == BS) && (guard < 50)) begin
         applyStimulus(1'b0, 1'b0, '0);
         guard++;
      end
      chk("push_wait_timeout", 32'(guard >= 50), 32'(0));
      applyStimulus(1'b1, eop, data);
   endtask

   task automatic drain();
      int guard = 0;
      while (((mq.size() > 0) || m_mid) && (guard < 100)) begin
         applyStimulus(1'b0, 1'b0, '0);
         guard++;
      end
      chk("drain_timeout", 32'(guard >= 100), 32'(0));
   endtask

   task automatic asyncReset();
      wr_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_tx", 32'(obs_tx), 32'(0));
      chk("rst_pkts", 32'(obs_pkts), 32'(0));
      chk("rst_err", 32'(obs_err), 32'(0));
      chk("rst_busy", 32'(obs_busy), 32'(0));
      chk("rst_full", 32'(obs_full), 32'(0));
      mq.delete();
      m_mid   = 1'b0;
      m_force = 1'b0;
      m_err   = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n   = 1'b1;
      sel     = 1'b0;
      wr_en   = 1'b0;
      wr_eop  = 1'b0;
      wr_data = '0;
      credit  = 1'b0;
      @(negedge clk);
      asyncReset();

      $display("[TB] cut-through three-flit packet");
      cr_mode   = 1;
      delivered = 0;
      pushFlit(1'b0, 32'h0000_0101);
      pushFlit(1'b0, 32'h0000_0002);
      pushFlit(1'b1, 32'h0000_0003);
      drain();
      chk("ct_delivered", 32'(delivered), 32'(3));

      $display("[TB] store-forward four-flit packet, slow producer");
      sel = 1'b1;
      asyncReset();
      delivered = 0;
      for (int i = 0; i < 4; i++) begin
         pushFlit(1'(i == 3), $urandom);
         if (i < 3) applyStimulus(1'b0, 1'b0, '0);
      end
      chk("sf_none_before_eop", 32'(delivered), 32'(0));
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, '0);
      chk("sf_back_to_back", 32'(delivered), 32'(4));

      $display("[TB] backpressure with credit 1,0,0 pattern");
      sel = 1'b0;
      asyncReset();
      cr_mode   = 2;
      cyc       = 0;
      delivered = 0;
      for (int i = 0; i < 5; i++) pushFlit(1'(i == 4), $urandom);
      drain();
      chk("bp_delivered", 32'(delivered), 32'(5));

      $display("[TB] full FIFO drops writes");
      asyncReset();
      cr_mode   = 0;
      delivered = 0;
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'(i == 3), 32'(32'hA0 + i));
      cr_mode = 1;
      applyStimulus(1'b1, 1'b0, 32'h0000_00FF);
      drain();
      chk("full_delivered", 32'(delivered), 32'(4));

      $display("[TB] oversize store-forward packet");
      sel = 1'b1;
      asyncReset();
      delivered = 0;
      for (int i = 0; i < 6; i++) pushFlit(1'(i == 5), $urandom);
      drain();
      chk("ovs_delivered", 32'(delivered), 32'(6));
      chk("ovs_err_sticky", 32'(obs_err), 32'(1));

      $display("[TB] async reset mid-packet");
      cr_mode = 0;
      for (int i = 0; i < 4; i++) pushFlit(1'(i == 3), $urandom);
      cr_mode   = 1;
      delivered = 0;
      applyStimulus(1'b0, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, '0);
      chk("mid_sent_two", 32'(delivered), 32'(2));
      asyncReset();
      delivered = 0;
      pushFlit(1'b0, $urandom);
      pushFlit(1'b1, $urandom);
      drain();
      chk("post_reset_delivered", 32'(delivered), 32'(2));

      $display("[TB] random traffic on both modes");
      for (int m = 0; m < 2; m++) begin
         sel = 1'(m);
         asyncReset();
         cr_mode = 3;
         for (int i = 0; i < 80; i++) begin
            applyStimulus(1'($urandom_range(1, 0)), 1'($urandom_range(3, 0) == 0), $urandom);
         end
         cr_mode = 1;
         pushFlit(1'b1, $urandom);
         drain();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
